alu_share_arbiter: RTL and testbench

//  Lets two requesters share one combinational ALU instance (SIZE-bit, 3-bit op

---
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared combinational ALU. It arbitrates
// round-robin, latches operands, and registers the result, flags and flag register.
module alu_share_alu #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    input  logic [2:0]      op_i,
    output logic [SIZE-1:0] result_o,
    output logic [3:0]      flags_o,
    output logic            illegal_o
);
    logic            sub;
    logic [SIZE-1:0] b_eff;
    logic [SIZE:0]   sum;
    logic            c;
    logic            v;

    // SUB is a + ~b + 1, so carry-out high means no borrow.
    assign sub   = (op_i == 3'b001);
    assign b_eff = sub ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + (SIZE+1)'(sub);

    always_comb begin
        result_o  = '0;
        c         = 1'b0;
        v         = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            3'b000, 3'b001: begin
                result_o = sum[SIZE-1:0];
                c        = sum[SIZE];
                v        = (a_i[SIZE-1] == b_eff[SIZE-1]) && (sum[SIZE-1] != a_i[SIZE-1]);
            end
            3'b010:  result_o = a_i & b_i;
            3'b011:  result_o = a_i | b_i;
            3'b100:  result_o = a_i ^ b_i;
            3'b101:  result_o = ~a_i;
            3'b110:  result_o = b_i;
            default: illegal_o = 1'b1;
        endcase
        flags_o = illegal_o ? 4'b0000 : {result_o[SIZE-1], (result_o == '0), c, v};
    end
endmodule

module alu_share_arbiter #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [SIZE-1:0] req0_a_i,
    input  logic [SIZE-1:0] req0_b_i,
    input  logic [2:0]      req0_op_i,
    input  logic            req0_fwr_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [SIZE-1:0] req1_a_i,
    input  logic [SIZE-1:0] req1_b_i,
    input  logic [2:0]      req1_op_i,
    input  logic            req1_fwr_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [SIZE-1:0] rsp_result_o,
    output logic [3:0]      rsp_flags_o,
    output logic            rsp_err_o,
    output logic [3:0]      flags_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_grant_q;
    logic [SIZE-1:0] a_q, b_q;
    logic [2:0]      op_q;
    logic            fwr_q, id_q;
    logic            rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [SIZE-1:0] rsp_result_q;
    logic [3:0]      rsp_flags_q, flags_q;

    logic            gnt0, gnt1, accept;
    logic [SIZE-1:0] alu_result;
    logic [3:0]      alu_flags;
    logic            alu_illegal;

    // On a tie the requester that did not win last time is served.
    assign gnt0         = req0_valid_i && (!req1_valid_i || last_grant_q);
    assign gnt1         = req1_valid_i && (!req0_valid_i || !last_grant_q);
    assign req0_ready_o = (state_q == IDLE) && gnt0;
    assign req1_ready_o = (state_q == IDLE) && gnt1;
    assign accept       = req0_ready_o || req1_ready_o;

    alu_share_alu #(.SIZE(SIZE)) u_alu (
        .a_i       (a_q),
        .b_i       (b_q),
        .op_i      (op_q),
        .result_o  (alu_result),
        .flags_o   (alu_flags),
        .illegal_o (alu_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            fwr_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            flags_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && accept) begin
                a_q          <= req1_ready_o ? req1_a_i   : req0_a_i;
                b_q          <= req1_ready_o ? req1_b_i   : req0_b_i;
                op_q         <= req1_ready_o ? req1_op_i  : req0_op_i;
                fwr_q        <= req1_ready_o ? req1_fwr_i : req0_fwr_i;
                id_q         <= req1_ready_o;
                last_grant_q <= req1_ready_o;
            end
            if (state_q == EXEC) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_result;
                rsp_flags_q  <= alu_flags;
                rsp_err_q    <= alu_illegal;
                if (fwr_q && !alu_illegal) flags_q <= alu_flags;
            end
            if (state_q == RESP && rsp_ready_i) rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign rsp_err_o    = rsp_err_q;
    assign flags_o      = flags_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: arbitration order, latency, backpressure,
// flag generation, illegal op handling and asynchronous reset mid-operation.
module tb_alu_share_arbiter;
    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req0_fwr;
    logic [15:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready, req1_fwr;
    logic [15:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags, flags;
    int          n_total, n_pass;

    alu_share_arbiter #(.SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a),
        .req0_b_i(req0_b), .req0_op_i(req0_op), .req0_fwr_i(req0_fwr),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a),
        .req1_b_i(req1_b), .req1_op_i(req1_op), .req1_fwr_i(req1_fwr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err),
        .flags_o(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set0(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic fwr);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_fwr = fwr;
    endtask

    task automatic set1(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic fwr);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_fwr = fwr;
    endtask

    task automatic chk_rsp(input string tag, input logic [15:0] res, input logic [3:0] fl,
                           input logic id, input logic err, input logic [3:0] fq);
        chk({tag, "_valid"},  32'(rsp_valid), 1);
        chk({tag, "_result"}, 32'(rsp_result), 32'(res));
        chk({tag, "_flags"},  32'(rsp_flags), 32'(fl));
        chk({tag, "_id"},     32'(rsp_id), 32'(id));
        chk({tag, "_err"},    32'(rsp_err), 32'(err));
        chk({tag, "_flagreg"}, 32'(flags), 32'(fq));
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        rst_n = 1'b0; rsp_ready = 1'b0;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_result", 32'(rsp_result), 0);
        chk("rst_flags", 32'(rsp_flags), 0);
        chk("rst_flagreg", 32'(flags), 0);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
        rst_n = 1'b1;

        // Both valid after reset: requester 0 wins the first tie.
        @(negedge clk);
        set0(1, 16'h7FFF, 16'h0001, 3'b000, 1);
        set1(1, 16'h0005, 16'h0005, 3'b001, 0);
        #1 chk("add_grant", 32'({req1_ready, req0_ready}), 'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        #1 chk("add_exec_valid", 32'(rsp_valid), 0);
        chk("add_exec_ready", 32'({req1_ready, req0_ready}), 0);
        @(negedge clk);
        chk_rsp("add", 16'h8000, 4'b1001, 0, 0, 4'b1001);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("add_drop_valid", 32'(rsp_valid), 0);
        chk("sub_grant", 32'({req1_ready, req0_ready}), 'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk_rsp("sub", 16'h0000, 4'b0110, 1, 0, 4'b1001);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Both requesters always valid: grants alternate 0,1,0,1.
        set0(1, 16'hFFFF, 16'h0F0F, 3'b010, 0);
        set1(1, 16'h00F0, 16'h0F00, 3'b011, 0);
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", 32'({req1_ready, req0_ready}), (k % 2 == 0) ? 'b01 : 'b10);
            @(negedge clk);
            chk("rr_exec_ready", 32'({req1_ready, req0_ready}), 0);
            @(negedge clk);
            chk("rr_id", 32'(rsp_id), 32'(k % 2));
            chk("rr_result", 32'(rsp_result), (k % 2 == 0) ? 'h0F0F : 'h0FF0);
            chk("rr_resp_ready", 32'({req1_ready, req0_ready}), 0);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end

        // Backpressure: response held for 5 cycles while req1 waits.
        set0(1, 16'h8000, 16'h0001, 3'b100, 1);
        set1(1, 16'h0000, 16'h1234, 3'b101, 0);
        #1 chk("bp_grant", 32'({req1_ready, req0_ready}), 'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk_rsp("bp_hold", 16'h8001, 4'b1000, 0, 0, 4'b1000);
            chk("bp_ready", 32'({req1_ready, req0_ready}), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("bp_next_grant", 32'({req1_ready, req0_ready}), 'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk_rsp("not", 16'hFFFF, 4'b1000, 1, 0, 4'b1000);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Illegal op with fwr: error, zeroed result/flags, flag register kept.
        set0(1, 16'h1234, 16'h5678, 3'b111, 1);
        #1 chk("ill_grant", 32'({req1_ready, req0_ready}), 'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk_rsp("ill", 16'h0000, 4'b0000, 0, 1, 4'b1000);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Pass b of zero: Z only, flag register updated.
        set0(1, 16'hFFFF, 16'h0000, 3'b110, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk_rsp("passb", 16'h0000, 4'b0100, 0, 0, 4'b0100);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset asserted during EXEC discards the op and clears state at once.
        set0(1, 16'hFFFF, 16'h0001, 3'b000, 1);
        #1 chk("rstx_grant", 32'({req1_ready, req0_ready}), 'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("rstx_valid", 32'(rsp_valid), 0);
        chk("rstx_flagreg", 32'(flags), 0);
        chk("rstx_flags", 32'(rsp_flags), 0);
        @(negedge clk);
        chk("rstx_no_rsp", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        set1(1, 16'h0000, 16'h0001, 3'b001, 1);
        #1 chk("rstx_req1_grant", 32'({req1_ready, req0_ready}), 'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        #1 chk("rstx_exec_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk_rsp("rstx_sub", 16'hFFFF, 4'b1000, 1, 0, 4'b1000);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rstx_drop", 32'(rsp_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
